// File: rtl/mips_pkg.sv
// Shared machine constants for the integer register file and its writeback path.
package mips_pkg;

    localparam int ADDR_SIZE = 5;
    localparam int WORD_SIZE = 32;
    localparam int NUM_REGS  = 2 ** ADDR_SIZE;

    localparam logic [ADDR_SIZE-1:0] REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: pipeline and long-unit write requests, long-op issue, busy flags
// and the registered regfile write port. master = requesters, slave = arbiter.
interface regfile_wb_arbiter_if
    import mips_pkg::*;
();

    logic                 p_valid;
    logic                 p_ready;
    logic [ADDR_SIZE-1:0] p_addr;
    logic [WORD_SIZE-1:0] p_data;

    logic                 l_valid;
    logic                 l_ready;
    logic [ADDR_SIZE-1:0] l_addr;
    logic [WORD_SIZE-1:0] l_data;

    logic                 l_issue_en;
    logic [ADDR_SIZE-1:0] l_issue_addr;
    logic [NUM_REGS-1:0]  busy;

    logic                 rd_en;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [WORD_SIZE-1:0] rd_data;

    modport master (
        output p_valid, p_addr, p_data,
        output l_valid, l_addr, l_data,
        output l_issue_en, l_issue_addr,
        input  p_ready, l_ready, busy,
        input  rd_en, rd_addr, rd_data
    );

    modport slave (
        input  p_valid, p_addr, p_data,
        input  l_valid, l_addr, l_data,
        input  l_issue_en, l_issue_addr,
        output p_ready, l_ready, busy,
        output rd_en, rd_addr, rd_data
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// regfile_scoreboard: one busy flag per register with a long-latency write in flight.
// Set on issue, cleared on long-unit writeback; a same-cycle set beats the clear.
module regfile_scoreboard
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en_i,
    input  logic [ADDR_SIZE-1:0] set_addr_i,
    input  logic                 clr_en_i,
    input  logic [ADDR_SIZE-1:0] clr_addr_i,
    output logic [NUM_REGS-1:0]  busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        // Applied after the clear so a re-issue to the completing register stays busy.
        if (set_en_i && (set_addr_i != REG_ZERO)) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    // NOTE: every flag is cleared by reset; a stale busy bit would stall the hazard unit forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline has priority, long unit is forced through after
// STARVE_MAX denied cycles. Define REGFILE_WB_SCOREBOARD_EN to build the busy scoreboard.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]     starve_q, starve_d;
    logic                 force_l;
    logic                 p_fire;
    logic                 l_fire;

    logic                 rd_en_q, rd_en_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;

    // Ready depends only on valids and the starvation count, never on the other side's ready.
    assign force_l     = (starve_q == CNT_MAX) && bus.l_valid;
    assign bus.p_ready = !force_l;
    assign bus.l_ready = force_l || (bus.l_valid && !bus.p_valid);

    assign p_fire = bus.p_valid && bus.p_ready;
    assign l_fire = bus.l_valid && bus.l_ready;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        starve_d  = '0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        if (bus.l_valid && !bus.l_ready) begin
            starve_d = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + CNT_W'(1);
        end

        if (l_fire) begin
            rd_en_d   = (bus.l_addr != REG_ZERO);
            rd_addr_d = bus.l_addr;
            rd_data_d = bus.l_data;
        end else if (p_fire) begin
            rd_en_d   = (bus.p_addr != REG_ZERO);
            rd_addr_d = bus.p_addr;
            rd_data_d = bus.p_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_data = rd_data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (bus.l_issue_en),
        .set_addr_i (bus.l_issue_addr),
        .clr_en_i   (l_fire),
        .clr_addr_i (bus.l_addr),
        .busy_o     (bus.busy)
    );
`else
    logic unused_issue;

    assign bus.busy     = '0;
    assign unused_issue = ^{bus.l_issue_en, bus.l_issue_addr};
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed cases then random traffic
// against a transaction-level model of the grant, writeback and busy rules.
module tb_regfile_wb_arbiter;
    import mips_pkg::*;

    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                   m_denied;
    logic [NUM_REGS-1:0]  m_busy;
    logic                 m_en;
    logic [ADDR_SIZE-1:0] m_addr;
    logic [WORD_SIZE-1:0] m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_denied = 0;
        m_busy   = '0;
        m_en     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // One clock: drive at negedge, check ready, apply edge to model, check outputs at next negedge.
    task automatic cycle(input logic pv, input logic [ADDR_SIZE-1:0] pa, input logic [WORD_SIZE-1:0] pd,
                         input logic lv, input logic [ADDR_SIZE-1:0] la, input logic [WORD_SIZE-1:0] ld,
                         input logic ie, input logic [ADDR_SIZE-1:0] ia,
                         output logic got_pr, output logic got_lr);
        logic exp_pr, exp_lr, forced;
        bus.p_valid = pv; bus.p_addr = pa; bus.p_data = pd;
        bus.l_valid = lv; bus.l_addr = la; bus.l_data = ld;
        bus.l_issue_en = ie; bus.l_issue_addr = ia;
        #1;
        forced = lv && (m_denied == STARVE_MAX);
        exp_pr = !forced;
        exp_lr = forced || (lv && !pv);
        got_pr = bus.p_ready;
        got_lr = bus.l_ready;
        check("p_ready", got_pr, exp_pr);
        check("l_ready", got_lr, exp_lr);
        @(posedge clk);
        if (lv && exp_lr) begin
            m_en = (la != 0); m_addr = la; m_data = ld;
            m_busy[la] = 1'b0;
        end else if (pv && exp_pr) begin
            m_en = (pa != 0); m_addr = pa; m_data = pd;
        end else begin
            m_en = 1'b0;
        end
`ifdef REGFILE_WB_SCOREBOARD_EN
        if (ie && ia != 0) m_busy[ia] = 1'b1;
`endif
        m_denied = (lv && !exp_lr) ? ((m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1) : 0;
        @(negedge clk);
        check("rd_en", bus.rd_en, m_en);
        if (m_en) begin
            check("rd_addr", bus.rd_addr, m_addr);
            check("rd_data", bus.rd_data, m_data);
        end
        check("busy", bus.busy, m_busy);
    endtask

    task automatic idle();
        logic pr, lr;
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, pr, lr);
    endtask

    initial begin
        logic       pr, lr;
        logic [4:0] lr_seq, pr_seq;

        bus.p_valid = 1'b0; bus.p_addr = '0; bus.p_data = '0;
        bus.l_valid = 1'b0; bus.l_addr = '0; bus.l_data = '0;
        bus.l_issue_en = 1'b0; bus.l_issue_addr = '0;
        model_reset();

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rd_en", bus.rd_en, 1'b0);
        check("reset_rd_addr", bus.rd_addr, 5'd0);
        check("reset_rd_data", bus.rd_data, 32'd0);
        check("reset_busy", bus.busy, '0);

        // Single pipeline write
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, pr, lr);
        check("single_rd_addr", bus.rd_addr, 5'd5);
        check("single_rd_data", bus.rd_data, 32'hDEADBEEF);
        idle();

        // Contention: long unit forced through on the fourth cycle
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 5'(i + 1), 32'h1000 + i, 1'b1, 5'd9, 32'h9999_0000 + i, 1'b0, '0, pr, lr);
            pr_seq[i] = pr;
            lr_seq[i] = lr;
            if (i == 3) check("contention_rd_addr", bus.rd_addr, 5'd9);
        end
        check("contention_l_ready_seq", lr_seq, 5'b01000);
        check("contention_p_ready_seq", pr_seq, 5'b10111);
        idle();

        // Zero register write is accepted but suppressed
        cycle(1'b1, 5'd0, 32'h1234_5678, 1'b0, '0, '0, 1'b0, '0, pr, lr);
        check("zero_rd_en", bus.rd_en, 1'b0);

        // Scoreboard set / clear / simultaneous / addr 0
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, pr, lr);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, '0, pr, lr);
        check("sb_clear_busy7", bus.busy[7], 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0001, 1'b1, 5'd7, pr, lr);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, pr, lr);
        check("sb_busy0", bus.busy[0], 1'b0);
        idle();

        // Reset mid-traffic
        cycle(1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b1, 5'd12, pr, lr);
        #2 rst = 1'b1;
        #1;
        check("midreset_rd_en", bus.rd_en, 1'b0);
        check("midreset_busy", bus.busy, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midreset_dropped", bus.rd_en, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) < 7), 5'($urandom), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)), pr, lr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
